acc_cpu_core: RTL and testbench

Parametrised multicycle accumulator CPU core: next generation of the team's 16-bit accumulator CPU, generalised in data and address width and given a stall-capable memory handshake, a carry flag, conditional branches and a HALT state. It sits between a single-port memory/bus slave and the SoC top. Datapath and FSM controller are merged into one core with a separate ALU.

---
 rtl/acc_cpu_pkg.sv | 48 ++++
 rtl/acc_cpu_if.sv | 25 ++
 rtl/acc_cpu_alu.sv | 37 +++
 rtl/acc_cpu_core.sv | 124 ++++++++++++
 tb/tb_acc_cpu_core.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU core.
// Holds the opcode encodings, the controller state encoding, the ALU
// operation encoding and the opcode-to-ALU-operation mapping.
package acc_cpu_pkg;

    localparam logic [3:0] OP_LDA  = 4'b0000;
    localparam logic [3:0] OP_STA  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_JMP  = 4'b0111;
    localparam logic [3:0] OP_JZ   = 4'b1000;
    localparam logic [3:0] OP_JC   = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_PASS,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOT
    } alu_op_e;

    // LDA, STA and all non-ALU opcodes map to PASS; the core decides
    // separately whether the ALU result is written back.
    function automatic alu_op_e alu_op_for(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_NOT:  return ALU_NOT;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/acc_cpu_if.sv
// Single-port memory/bus handshake between the CPU core (master) and a
// memory or bus slave.
//   mem_req/mem_we/mem_addr/mem_wdata : request, driven by the master
//   mem_rdata/mem_ack                 : completion, driven by the slave
interface acc_cpu_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/acc_cpu_alu.sv
// Combinational ALU for the accumulator CPU.
//   acc, operand : DATA_W-bit inputs
//   alu_op       : operation select
//   c_in         : current carry flag, passed through by logic ops
//   result       : DATA_W-bit result
//   c_out        : new carry (carry for ADD, borrow for SUB)
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    input  alu_op_e           alu_op,
    input  logic              c_in,
    output logic [DATA_W-1:0] result,
    output logic              c_out
);

    always_comb begin
        result = acc;
        c_out  = c_in;
        case (alu_op)
            ALU_PASS: result = operand;
            ALU_ADD:  {c_out, result} = {1'b0, acc} + {1'b0, operand};
            ALU_SUB: begin
                result = acc - operand;
                c_out  = (acc < operand);
            end
            ALU_AND:  result = acc & operand;
            ALU_OR:   result = acc | operand;
            ALU_NOT:  result = ~acc;
            default:  ;
        endcase
    end

endmodule

// File: rtl/acc_cpu_core.sv
// Multicycle accumulator CPU core: controller FSM plus pc/ir/acc/carry.
//   clk, rst   : clock and asynchronous active-low reset
//   bus        : memory handshake (master side)
//   halted     : core has executed HALT
//   acc_dbg    : accumulator
//   pc_dbg     : program counter
//   carry_dbg  : carry flag
//
// state    | meaning
// ---------+-----------------------------------------------
// S_BOOT   | one idle cycle after reset release
// S_FETCH  | read instruction at pc, wait for ack
// S_DECODE | execute register/branch ops, pick next state
// S_MEM    | data access at ir address, wait for ack
// S_HALT   | stopped until reset
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int               DATA_W   = 16,
    parameter int               ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    acc_cpu_if.master         bus,
    output logic              halted,
    output logic [DATA_W-1:0] acc_dbg,
    output logic [ADDR_W-1:0] pc_dbg,
    output logic              carry_dbg
);

    if (ADDR_W > DATA_W - 4) begin : g_bad_addr_w
        $error("acc_cpu_core: ADDR_W must not exceed DATA_W-4");
    end

    state_e            state;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        ir_op;
    logic [ADDR_W-1:0] ir_a;
    logic [DATA_W-1:0] acc;
    logic              c;

    alu_op_e           alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_c;

    // Only the opcode and address fields of the instruction are ever used,
    // so the instruction register keeps just those two fields.
    assign alu_op = alu_op_for(ir_op);

    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .acc     (acc),
        .operand (bus.mem_rdata),
        .alu_op  (alu_op),
        .c_in    (c),
        .result  (alu_result),
        .c_out   (alu_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_BOOT;
            pc    <= RESET_PC;
            ir_op <= '0;
            ir_a  <= '0;
            acc   <= '0;
            c     <= 1'b0;
        end else begin
            case (state)
                S_BOOT: state <= S_FETCH;

                S_FETCH: begin
                    if (bus.mem_ack) begin
                        ir_op <= bus.mem_rdata[DATA_W-1 -: 4];
                        ir_a  <= bus.mem_rdata[ADDR_W-1:0];
                        pc    <= pc + ADDR_W'(1);
                        state <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    state <= S_FETCH;
                    case (ir_op)
                        OP_LDA, OP_STA, OP_ADD,
                        OP_SUB, OP_AND, OP_OR:  state <= S_MEM;
                        OP_NOT:  acc <= alu_result;
                        OP_JMP:  pc  <= ir_a;
                        OP_JZ:   if (acc == '0) pc <= ir_a;
                        OP_JC:   if (c) pc <= ir_a;
                        OP_HALT: state <= S_HALT;
                        default: ;
                    endcase
                end

                S_MEM: begin
                    if (bus.mem_ack) begin
                        if (ir_op != OP_STA) begin
                            acc <= alu_result;
                            c   <= alu_c;
                        end
                        state <= S_FETCH;
                    end
                end

                S_HALT: ;

                default: state <= S_BOOT;
            endcase
        end
    end

    // Request signals decode only registered state, so they hold steady
    // through wait states and drop with reset without a clock.
    assign bus.mem_req   = (state == S_FETCH) || (state == S_MEM);
    assign bus.mem_we    = (state == S_MEM) && (ir_op == OP_STA);
    assign bus.mem_addr  = (state == S_MEM) ? ir_a : pc;
    assign bus.mem_wdata = acc;

    assign halted    = (state == S_HALT);
    assign acc_dbg   = acc;
    assign pc_dbg    = pc;
    assign carry_dbg = c;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed testbench for acc_cpu_core with a behavioural memory responder
// that has a programmable number of wait states.
module tb_acc_cpu_core;

    localparam logic [11:0] RESET_PC = 12'h010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halted;
    logic [15:0] acc_dbg;
    logic [11:0] pc_dbg;
    logic        carry_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:4095];
    bit          resp_en = 1'b1;
    int          wait_n  = 0;
    int          wcnt    = 0;

    acc_cpu_if #(.DATA_W(16), .ADDR_W(12)) bus ();

    acc_cpu_core #(.DATA_W(16), .ADDR_W(12), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .halted    (halted),
        .acc_dbg   (acc_dbg),
        .pc_dbg    (pc_dbg),
        .carry_dbg (carry_dbg)
    );

    always #5 clk = ~clk;

    // Memory responder: acks after wait_n idle request cycles.
    always @(negedge clk) begin
        if (!resp_en) begin
            wcnt = 0;
        end else if (bus.mem_req) begin
            if (bus.mem_ack) wcnt = 0;
            if (wcnt == wait_n) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr];
                if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            end else begin
                bus.mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
        end
    end

    task automatic to_neg(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        resp_en = 1'b1;
        wait_n = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        mem[12'h010] = 16'hA000;
        mem[12'h011] = 16'hF000;
        #1;
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: req=%b we=%b required 0 0", bus.mem_req, bus.mem_we);
        end
        n_checks++;
        if ({halted, carry_dbg, acc_dbg, pc_dbg} !== {1'b0, 1'b0, 16'h0000, 12'h010}) begin
            n_fail++; $display("FAIL reset_regs: halted=%b c=%b acc=%h pc=%h required 0 0 0000 010",
                               halted, carry_dbg, acc_dbg, pc_dbg);
        end
        release_reset();
        #1;
        n_checks++;
        if (bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL boot_idle: req=%b required 0", bus.mem_req);
        end
        to_neg(1);
        n_checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 12'h010}) begin
            n_fail++; $display("FAIL first_fetch: req=%b we=%b addr=%h required 1 0 010",
                               bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        to_neg(1);
        n_checks++;
        if (pc_dbg !== 12'h011 || bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL fetch_pc: pc=%h req=%b required 011 0", pc_dbg, bus.mem_req);
        end
    endtask

    task automatic test_add_carry_jc();
        apply_reset();
        mem[12'h010] = 16'h0100;
        mem[12'h011] = 16'h2101;
        mem[12'h012] = 16'h9020;
        mem[12'h020] = 16'hF000;
        mem[12'h100] = 16'hFFFF;
        mem[12'h101] = 16'h0002;
        release_reset();
        to_neg(1);
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 12'h010) begin
            n_fail++; $display("FAIL jc_start: req=%b addr=%h required 1 010", bus.mem_req, bus.mem_addr);
        end
        to_neg(3);
        n_checks++;
        if (acc_dbg !== 16'hFFFF || bus.mem_addr !== 12'h011) begin
            n_fail++; $display("FAIL lda_ffff: acc=%h addr=%h required FFFF 011", acc_dbg, bus.mem_addr);
        end
        to_neg(4);
        n_checks++;
        if (bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL jc_decode_idle: req=%b required 0", bus.mem_req);
        end
        to_neg(1);
        n_checks++;
        if (acc_dbg !== 16'h0001 || carry_dbg !== 1'b1) begin
            n_fail++; $display("FAIL add_carry: acc=%h c=%b required 0001 1", acc_dbg, carry_dbg);
        end
        n_checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, pc_dbg} !== {1'b1, 1'b0, 12'h020, 12'h020}) begin
            n_fail++; $display("FAIL jc_taken: req=%b we=%b addr=%h pc=%h required 1 0 020 020",
                               bus.mem_req, bus.mem_we, bus.mem_addr, pc_dbg);
        end
    endtask

    task automatic test_sta_wait();
        bit found;
        apply_reset();
        mem[12'h010] = 16'h0080;
        mem[12'h011] = 16'h10FF;
        mem[12'h012] = 16'hF000;
        mem[12'h080] = 16'hA5A5;
        wait_n = 3;
        release_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            to_neg(1);
            if (bus.mem_req === 1'b1 && bus.mem_we === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (found !== 1'b1) begin
            n_fail++; $display("FAIL sta_seen: store request seen=%b required 1", found);
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) to_neg(1);
            n_checks++;
            if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 12'h0FF, 16'hA5A5}) begin
                n_fail++; $display("FAIL sta_hold%0d: req=%b we=%b addr=%h wdata=%h required 1 1 0FF A5A5",
                                   k, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
            end
        end
        to_neg(1);
        n_checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, pc_dbg} !== {1'b1, 1'b0, 12'h012, 12'h012}) begin
            n_fail++; $display("FAIL sta_next_fetch: req=%b we=%b addr=%h pc=%h required 1 0 012 012",
                               bus.mem_req, bus.mem_we, bus.mem_addr, pc_dbg);
        end
        n_checks++;
        if (mem[12'h0FF] !== 16'hA5A5) begin
            n_fail++; $display("FAIL sta_mem: M[0FF]=%h required A5A5", mem[12'h0FF]);
        end
    endtask

    task automatic test_sub_jz();
        apply_reset();
        mem[12'h010] = 16'h0080;
        mem[12'h011] = 16'h3005;
        mem[12'h012] = 16'h8040;
        mem[12'h013] = 16'hF000;
        mem[12'h080] = 16'h0003;
        mem[12'h005] = 16'h0007;
        release_reset();
        to_neg(7);
        n_checks++;
        if (acc_dbg !== 16'hFFFC || carry_dbg !== 1'b1) begin
            n_fail++; $display("FAIL sub_borrow: acc=%h c=%b required FFFC 1", acc_dbg, carry_dbg);
        end
        to_neg(1);
        n_checks++;
        if (bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL jz_decode_idle: req=%b required 0", bus.mem_req);
        end
        to_neg(1);
        n_checks++;
        if ({bus.mem_req, bus.mem_addr, pc_dbg} !== {1'b1, 12'h013, 12'h013}) begin
            n_fail++; $display("FAIL jz_not_taken: req=%b addr=%h pc=%h required 1 013 013",
                               bus.mem_req, bus.mem_addr, pc_dbg);
        end
    endtask

    task automatic test_wrap_halt();
        int bad;
        apply_reset();
        mem[12'h010] = 16'h0080;
        mem[12'h011] = 16'h7FFF;
        mem[12'hFFF] = 16'h6000;
        mem[12'h000] = 16'hF000;
        mem[12'h080] = 16'h1234;
        release_reset();
        to_neg(6);
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 12'hFFF) begin
            n_fail++; $display("FAIL jmp_fff: req=%b addr=%h required 1 FFF", bus.mem_req, bus.mem_addr);
        end
        to_neg(1);
        n_checks++;
        if (pc_dbg !== 12'h000) begin
            n_fail++; $display("FAIL pc_wrap: pc=%h required 000", pc_dbg);
        end
        to_neg(1);
        n_checks++;
        if ({bus.mem_req, bus.mem_addr, acc_dbg} !== {1'b1, 12'h000, 16'hEDCB}) begin
            n_fail++; $display("FAIL not_wrap: req=%b addr=%h acc=%h required 1 000 EDCB",
                               bus.mem_req, bus.mem_addr, acc_dbg);
        end
        to_neg(2);
        n_checks++;
        if (halted !== 1'b1 || bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL halt_enter: halted=%b req=%b required 1 0", halted, bus.mem_req);
        end
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            to_neg(1);
            if (halted !== 1'b1 || bus.mem_req !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL halt_stay: bad cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_reset_mid_mem();
        apply_reset();
        mem[12'h010] = 16'h0080;
        mem[12'h011] = 16'h2081;
        mem[12'h012] = 16'hF000;
        mem[12'h080] = 16'h5555;
        mem[12'h081] = 16'h0001;
        release_reset();
        to_neg(5);
        resp_en = 1'b0;
        bus.mem_ack = 1'b0;
        to_neg(3);
        n_checks++;
        if ({bus.mem_req, bus.mem_addr, acc_dbg, pc_dbg} !== {1'b1, 12'h081, 16'h5555, 12'h012}) begin
            n_fail++; $display("FAIL mem_stall: req=%b addr=%h acc=%h pc=%h required 1 081 5555 012",
                               bus.mem_req, bus.mem_addr, acc_dbg, pc_dbg);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_req, bus.mem_we, halted} !== 3'b000) begin
            n_fail++; $display("FAIL async_reset_out: req=%b we=%b halted=%b required 0 0 0",
                               bus.mem_req, bus.mem_we, halted);
        end
        n_checks++;
        if ({acc_dbg, pc_dbg, carry_dbg} !== {16'h0000, 12'h010, 1'b0}) begin
            n_fail++; $display("FAIL async_reset_regs: acc=%h pc=%h c=%b required 0000 010 0",
                               acc_dbg, pc_dbg, carry_dbg);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        bus.mem_rdata = 16'hF000;
        bus.mem_ack = 1'b1;
        to_neg(1);
        n_checks++;
        if ({bus.mem_req, bus.mem_addr, pc_dbg} !== {1'b1, 12'h010, 12'h010}) begin
            n_fail++; $display("FAIL late_ack_ignored: req=%b addr=%h pc=%h required 1 010 010",
                               bus.mem_req, bus.mem_addr, pc_dbg);
        end
        bus.mem_ack = 1'b0;
        resp_en = 1'b1;
        to_neg(2);
        n_checks++;
        if (pc_dbg !== 12'h011 || halted !== 1'b0) begin
            n_fail++; $display("FAIL refetch: pc=%h halted=%b required 011 0", pc_dbg, halted);
        end
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_add_carry_jc();
        test_sta_wait();
        test_sub_jz();
        test_wrap_halt();
        test_reset_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
